// File: rtl/regfile_wb_sched_if.sv
// Writeback, issue and register-file write bundle of the scheduler.
// The core/bench side is the master; the scheduler is the slave.
interface regfile_wb_sched_if #(
  parameter int WIDTH = 32,
  parameter int NUM   = 32
);
  localparam int AW = $clog2(NUM);

  logic             issue_valid;
  logic [AW-1:0]    issue_rs1;
  logic [AW-1:0]    issue_rs2;
  logic [AW-1:0]    issue_rd;
  logic             issue_stall;
  logic             alu_valid;
  logic [AW-1:0]    alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             alu_ready;
  logic             mem_valid;
  logic [AW-1:0]    mem_rd;
  logic [WIDTH-1:0] mem_data;
  logic             mem_ready;
  logic [AW-1:0]    address_w;
  logic [WIDTH-1:0] data_w;
  logic             wb_error;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  issue_stall, alu_ready, mem_ready,
    input  address_w, data_w, wb_error
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output issue_stall, alu_ready, mem_ready,
    output address_w, data_w, wb_error
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Round-robin ALU/load arbiter onto the single register-file write port,
// plus a busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int WIDTH = 32,
  parameter int NUM   = 32
) (
  input logic              clock,
  input logic              reset,
  regfile_wb_sched_if.slave bus
);
  localparam int AW = $clog2(NUM);

  logic [NUM-1:0]   busy_q, busy_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]    address_w_q, address_w_d;
  logic [WIDTH-1:0] data_w_q, data_w_d;
  logic             wb_error_q, wb_error_d;

  logic alu_req_s, mem_req_s, grant_alu_s, grant_mem_s;
  logic hazard_s, issue_set_s, wr_clr_s;
  logic alu_ready_s, mem_ready_s, issue_stall_s;

  // Arbitration, hazard detection and handshake outputs
  always_comb begin
    alu_req_s   = bus.alu_valid && (bus.alu_rd != {AW{1'b0}});
    mem_req_s   = bus.mem_valid && (bus.mem_rd != {AW{1'b0}});
    // rr_ptr_q = 1 favours the ALU when both contend
    grant_alu_s = alu_req_s && (!mem_req_s || rr_ptr_q);
    grant_mem_s = mem_req_s && (!alu_req_s || !rr_ptr_q);
    hazard_s    = busy_q[bus.issue_rs1] | busy_q[bus.issue_rs2] | busy_q[bus.issue_rd];
    if (reset) begin
      alu_ready_s   = 1'b0;
      mem_ready_s   = 1'b0;
      issue_stall_s = 1'b0;
    end else begin
      alu_ready_s   = grant_alu_s || (bus.alu_valid && !alu_req_s);
      mem_ready_s   = grant_mem_s || (bus.mem_valid && !mem_req_s);
      issue_stall_s = bus.issue_valid && hazard_s;
    end
  end

  // Next-state for scoreboard, round-robin pointer, write port and error flag
  always_comb begin
    issue_set_s = bus.issue_valid && !hazard_s && (bus.issue_rd != {AW{1'b0}});
    wr_clr_s    = (address_w_q != {AW{1'b0}});
    // set is applied after clear so a colliding set wins
    for (int i = 0; i < NUM; i++) begin
      busy_d[i] = (issue_set_s && (bus.issue_rd == AW'(i))) ||
                  (busy_q[i] && !(wr_clr_s && (address_w_q == AW'(i))));
    end
    rr_ptr_d   = (alu_req_s && mem_req_s) ? grant_mem_s : rr_ptr_q;
    wb_error_d = wb_error_q | (wr_clr_s && !busy_q[address_w_q]);
    case ({grant_alu_s, grant_mem_s})
      2'b10: begin
        address_w_d = bus.alu_rd;
        data_w_d    = bus.alu_data;
      end
      2'b01: begin
        address_w_d = bus.mem_rd;
        data_w_d    = bus.mem_data;
      end
      default: begin
        address_w_d = {AW{1'b0}};
        data_w_d    = data_w_q;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q      <= {NUM{1'b0}};
      rr_ptr_q    <= 1'b0;
      address_w_q <= {AW{1'b0}};
      data_w_q    <= {WIDTH{1'b0}};
      wb_error_q  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rr_ptr_q    <= rr_ptr_d;
      address_w_q <= address_w_d;
      data_w_q    <= data_w_d;
      wb_error_q  <= wb_error_d;
    end
  end

  assign bus.alu_ready   = alu_ready_s;
  assign bus.mem_ready   = mem_ready_s;
  assign bus.issue_stall = issue_stall_s;
  assign bus.address_w   = address_w_q;
  assign bus.data_w      = data_w_q;
  assign bus.wb_error    = wb_error_q;
endmodule

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-port scheduler and hazard scoreboard for the core's single-write-port register file. It arbitrates two writeback sources (ALU and load unit) onto the one `address_w`/`data_w` port with round-robin fairness. It tracks which architectural registers have a result in flight, and stalls issue on RAW/WAW hazards until the write has landed.

## Interface
- `WIDTH`, 32, data width of register file entries.
- `NUM`, 32, number of architectural registers; index width `AW = $clog2(NUM)`.

- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `issue_valid` in 1: an instruction is presented for issue.
- `issue_rs1` in AW: first source register of the issuing instruction.
- `issue_rs2` in AW: second source register.
- `issue_rd` in AW: destination register; 0 means no writeback.
- `issue_stall` out 1: issue must hold this cycle (combinational).
- `alu_valid` in 1: ALU writeback request.
- `alu_rd` in AW: ALU destination register.
- `alu_data` in WIDTH: ALU result.
- `alu_ready` out 1: ALU request accepted this cycle (combinational).
- `mem_valid` in 1: load-unit writeback request.
- `mem_rd` in AW: load destination register.
- `mem_data` in WIDTH: load result.
- `mem_ready` out 1: load request accepted this cycle (combinational).
- `address_w` out AW: register-file write address (registered); 0 = no write.
- `data_w` out WIDTH: register-file write data (registered).
- `wb_error` out 1: sticky flag, set when a write commits to a register not marked busy.

## Operation
- **State:**
  - `busy[NUM-1:0]` scoreboard.
  - `rr_ptr`: 1 bit; 0 = mem preferred, 1 = alu preferred.
  - Output registers `address_w`, `data_w`.
  - `wb_error`.
- **Null requests:** a request with `rd == 0` is always ready in the cycle it is valid. It does not use the port, does not affect `rr_ptr`, and produces no write.
- **Arbitration:** applies to valid requests with nonzero `rd`.
  - One requester only: that requester is granted.
  - Both requesting: the requester selected by `rr_ptr` is granted, and `rr_ptr` flips to favour the loser.
  - Single-requester grants leave `rr_ptr` unchanged.
  - `*_ready` = grant for that requester; the loser sees ready=0 and must hold valid, rd and data stable.
- **Write stage:**
  - On a grant, the next edge loads `address_w <= rd` and `data_w <= data`.
  - With no grant, the next edge loads `address_w <= 0`; `data_w` holds its value.
  - The port accepts one write per cycle with no backpressure beyond arbitration.
- **Scoreboard set:** `issue_valid && !issue_stall && issue_rd != 0` sets `busy[issue_rd]` at the edge.
- **Scoreboard clear:** when `address_w != 0`, the edge clears `busy[address_w]`. This is the same edge at which the register file captures the data.
- **Stall:** `issue_stall = issue_valid && (busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd])`.
  - `busy[0]` is never set, so x0 never stalls.
  - Including `rd` in the check blocks WAW hazards.
- **Set/clear collision:** set and clear of the same index in one cycle cannot occur legally, because rd busy forces a stall. If it does occur, set wins.
- **wb_error:** when `address_w != 0` and `busy[address_w] == 0`, the edge sets `wb_error`. It clears only on reset.

## Timing
- **Reset** (sync, takes effect at the edge with `reset = 1`):
  - `busy` = 0, `rr_ptr` = 0 (mem first).
  - `address_w` = 0, `data_w` = 0, `wb_error` = 0.
  - In-flight writes are dropped.
  - While `reset` is high, `alu_ready`, `mem_ready` and `issue_stall` are forced to 0, and no issue sets busy.
- **Writeback latency:**
  - Handshake in cycle T.
  - `address_w`/`data_w` presented in T+1.
  - Register file updated and busy cleared at the end of T+1.
  - `issue_stall` on that register drops in T+2.
- **Issue-to-stall:** an issue accepted in cycle T makes `busy[rd]` visible in T+1.
- **Combinational paths:**
  - `*_ready` depend only on valids, rds and `rr_ptr`.
  - `issue_stall` depends only on issue inputs and `busy`.
  - No path from ready to valid.
- **Throughput:** sustained 1 write per cycle. With both sources valid every cycle, grants alternate strictly.

## Test plan
- **Reset:** assert reset 2 cycles with all valids high → ready=0, stall=0, `address_w`=0, `data_w`=0, `wb_error`=0. After reset, with both requesting rd=5 and rd=6, mem is granted first.
- **Round-robin:** alu(rd=3, data=0xAAAA) and mem(rd=4, data=0x5555) both held valid → mem granted at T, alu at T+1. `address_w`=4 at T+1, `address_w`=3 at T+2; `rr_ptr` ends at 0.
- **RAW stall:**
  - Issue rd=7 at T0.
  - Issue rs1=7 at T1 → `issue_stall`=1.
  - alu writes rd=7 at T3 → `address_w`=7 at T4.
  - `issue_stall`=0 at T5.
- **WAW and x0:**
  - Issue rd=9, then rd=9 next cycle → second stalls.
  - Issue rs1=0, rs2=0, rd=0 → never stalls.
  - mem request with rd=0 → `mem_ready`=1 same cycle, `address_w` stays 0.
- **Error flag:** alu writes rd=12 with `busy[12]`=0 → `wb_error`=1 one cycle after `address_w`=12; stays 1 until reset.
- **Reset mid-flight:** issue rd=2, grant write rd=2, assert reset in the write cycle → `address_w`=0 next cycle, `busy[2]`=0, a subsequent rs1=2 issue does not stall.
